// File: rtl/mem_responder.sv
// mem_responder: turns one 16-bit MAR/MDR request into one (byte) or two
// (word, little-endian) byte accesses on an 8-bit RAM port.
//
// Parameters
//   WAIT_STATES  extra idle cycles inside each byte phase (0..15)
// Ports
//   Clock, Reset          clock and synchronous active-high reset
//   req_en/rw/byte        request valid, 0=read 1=write, 0=word 1=byte
//   req_addr, req_wdata   MAR and MDR values, latched at acceptance
//   rsp_rdata             read result for the MDR
//   rsp_done              one-cycle completion pulse
//   busy                  high from acceptance through the DONE cycle
//   mem_addr/wdata/we/re  byte-wide RAM request, strobes one cycle long
//   mem_rdata             RAM read data, valid the cycle after mem_re
//
// All outputs are registered and computed for the state being entered, so a
// phase's strobe is visible in the first cycle that the FSM spends in it.
module mem_responder #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_en,
  input  logic        req_rw,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [15:0] rsp_rdata,
  output logic        rsp_done,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  // Phase counter runs 0 (strobe) .. WAIT_STATES+1 (capture); 16 needs 5 bits.
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_STATES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic             byte_q, byte_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_done_q, rsp_done_d;
  logic             busy_q, busy_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_re_q, mem_re_d;

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_done_q  <= rsp_done_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_done_d  = 1'b0;
    busy_d      = 1'b1;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_en) begin
          // Latch the request and issue the low-byte strobe right away.
          state_d     = LO;
          cnt_d       = '0;
          rw_d        = req_rw;
          byte_d      = req_byte;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata[7:0];
          mem_we_d    = req_rw;
          mem_re_d    = ~req_rw;
        end else begin
          busy_d = 1'b0;
        end
      end

      LO: begin
        if (cnt_q == LAST_CNT) begin
          // Capture cycle of the low byte.
          if (!rw_q) begin
            rsp_rdata_d[7:0] = mem_rdata;
            if (byte_q) begin
              rsp_rdata_d[15:8] = 8'h00;
            end
          end
          if (byte_q) begin
            state_d    = DONE;
            rsp_done_d = 1'b1;
          end else begin
            // Start the high-byte phase; the address wraps at 16 bits.
            state_d     = HI;
            cnt_d       = '0;
            mem_addr_d  = addr_q + 16'd1;
            mem_wdata_d = wdata_q[15:8];
            mem_we_d    = rw_q;
            mem_re_d    = ~rw_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HI: begin
        if (cnt_q == LAST_CNT) begin
          if (!rw_q) begin
            rsp_rdata_d[15:8] = mem_rdata;
          end
          state_d    = DONE;
          rsp_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_done  = rsp_done_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with no wait states and one
// with three, sharing the request inputs and a 64 KiB byte RAM model. The
// instance not under test is held in reset. A "done edge" is the count of
// rising edges from the acceptance edge to the edge that samples rsp_done=1.
module tb_mem_responder;

  logic        Clock;
  logic        rst0, rst3;
  logic        req_en, req_rw, req_byte;
  logic [15:0] req_addr, req_wdata;

  logic [15:0] rsp_rdata0, rsp_rdata3, mem_addr0, mem_addr3;
  logic        rsp_done0, rsp_done3, busy0, busy3;
  logic [7:0]  mem_wdata0, mem_wdata3, mem_rdata0, mem_rdata3;
  logic        mem_we0, mem_we3, mem_re0, mem_re3;

  mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .Clock(Clock), .Reset(rst0), .req_en(req_en), .req_rw(req_rw),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata0), .rsp_done(rsp_done0), .busy(busy0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
    .mem_re(mem_re0), .mem_rdata(mem_rdata0)
  );

  mem_responder #(.WAIT_STATES(3)) u_dut3 (
    .Clock(Clock), .Reset(rst3), .req_en(req_en), .req_rw(req_rw),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata3), .rsp_done(rsp_done3), .busy(busy3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3),
    .mem_re(mem_re3), .mem_rdata(mem_rdata3)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM model; it shares each responder's reset and drops write strobes
  // while that reset is asserted.
  logic [7:0]  ram [0:65535];
  logic        tb_we;
  logic [15:0] tb_a;
  logic [7:0]  tb_d;

  logic [23:0] wlog0[$];
  logic [15:0] relog0[$];
  int          re3_cyc[$];
  int          done0_cnt = 0;
  int          cyc = 0;

  always @(posedge Clock) begin
    if (tb_we) ram[tb_a] <= tb_d;
    if (mem_we0 && !rst0) ram[mem_addr0] <= mem_wdata0;
    if (mem_we3 && !rst3) ram[mem_addr3] <= mem_wdata3;
    if (mem_re0) mem_rdata0 <= ram[mem_addr0];
    if (mem_re3) mem_rdata3 <= ram[mem_addr3];
    if (mem_we0) wlog0.push_back({mem_addr0, mem_wdata0});
    if (mem_re0) relog0.push_back(mem_addr0);
    if (mem_re3) re3_cyc.push_back(cyc);
    if (rsp_done0) done0_cnt++;
    cyc++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic ram_poke(input logic [15:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    @(posedge Clock); #1;
    tb_we = 1'b0;
  endtask

  // Issue one request to the selected instance; returns the done edge or -1.
  task automatic run_req(input bit sel, input logic rw, input logic byt,
                         input logic [15:0] addr, input logic [15:0] wd,
                         output int done_edge);
    @(posedge Clock); #1;
    req_en = 1'b1; req_rw = rw; req_byte = byt; req_addr = addr; req_wdata = wd;
    @(posedge Clock); #1;
    req_en = 1'b0;
    done_edge = -1;
    for (int e = 1; e <= 40; e++) begin
      if ((sel ? rsp_done3 : rsp_done0) === 1'b1) begin
        done_edge = e;
        break;
      end
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          de, d0, r0, w0;
  logic [10:0] busy_tr;

  initial begin
    rst0 = 1'b1; rst3 = 1'b1; tb_we = 1'b0; tb_a = '0; tb_d = '0;
    req_en = 1'b0; req_rw = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge Clock);
    #1;

    // Reset state
    check("rst_rdata", 32'(rsp_rdata0), 32'h0);
    check("rst_addr", 32'(mem_addr0), 32'h0);
    check("rst_ctl", {19'd0, rsp_done0, busy0, mem_we0, mem_re0, mem_wdata0}, 32'h0);

    // Preload RAM while both instances sit in reset
    ram_poke(16'h1000, 8'h34); ram_poke(16'h1001, 8'h12);
    ram_poke(16'h2000, 8'h5A); ram_poke(16'h2001, 8'hAB);
    ram_poke(16'h3000, 8'hFF); ram_poke(16'h3001, 8'hFF);
    ram_poke(16'h4000, 8'h00); ram_poke(16'h4001, 8'h77);
    ram_poke(16'h0000, 8'h00); ram_poke(16'hFFFF, 8'h00);

    // Reset wins over a simultaneous request
    req_en = 1'b1; req_addr = 16'h1000;
    @(posedge Clock); #1;
    check("rst_prio_busy", 32'(busy0), 32'h0);
    check("rst_prio_re", 32'(mem_re0), 32'h0);
    rst0 = 1'b0; req_en = 1'b0;
    @(posedge Clock); #1;
    check("rst_prio_idle", 32'(busy0), 32'h0);

    // Word read, no wait states
    d0 = done0_cnt;
    run_req(1'b0, 1'b0, 1'b0, 16'h1000, 16'h0, de);
    check("wrd_done_edge", 32'(de), 32'd5);
    check("wrd_rdata", 32'(rsp_rdata0), 32'h1234);
    @(posedge Clock); #1;
    check("wrd_done_pulses", 32'(done0_cnt - d0), 32'd1);
    check("wrd_idle_busy", 32'(busy0), 32'h0);

    // Byte read clears the upper byte of a prior 0xFFFF
    run_req(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0, de);
    check("pre_rdata", 32'(rsp_rdata0), 32'hFFFF);
    run_req(1'b0, 1'b0, 1'b1, 16'h2001, 16'h0, de);
    check("byt_done_edge", 32'(de), 32'd3);
    check("byt_rdata", 32'(rsp_rdata0), 32'h00AB);

    // Word write wrapping past 0xFFFF
    w0 = wlog0.size();
    run_req(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hBEEF, de);
    check("wr_done_edge", 32'(de), 32'd5);
    check("wr_count", 32'(wlog0.size() - w0), 32'd2);
    check("wr_lo", 32'(wlog0[w0]), 32'hFFFFEF);
    check("wr_hi", 32'(wlog0[w0 + 1]), 32'h0000BE);
    check("wr_rdata_hold", 32'(rsp_rdata0), 32'h00AB);
    check("wr_ram", {16'd0, ram[16'hFFFF], ram[16'h0000]}, 32'hEFBE);

    // Back-to-back word reads with req_addr changing mid-request
    @(posedge Clock); #1;
    req_en = 1'b1; req_rw = 1'b0; req_byte = 1'b0; req_addr = 16'h1000;
    r0 = relog0.size();
    @(posedge Clock); #1;
    req_addr = 16'h2000;
    busy_tr = '0;
    busy_tr[0] = busy0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clock); #1;
      busy_tr[k] = busy0;
      if (k == 4) check("b2b_first_rdata", 32'(rsp_rdata0), 32'h1234);
      if (k == 6) req_en = 1'b0;
    end
    check("b2b_busy_trace", 32'(busy_tr), 32'h7DF);
    check("b2b_second_rdata", 32'(rsp_rdata0), 32'hAB5A);
    check("b2b_reads", 32'(relog0.size() - r0), 32'd4);
    check("b2b_addr0", 32'(relog0[r0]), 32'h1000);
    check("b2b_addr1", 32'(relog0[r0 + 1]), 32'h1001);
    check("b2b_addr2", 32'(relog0[r0 + 2]), 32'h2000);
    check("b2b_addr3", 32'(relog0[r0 + 3]), 32'h2001);

    // Reset during the HI strobe cycle of a word write
    @(posedge Clock); #1;
    d0 = done0_cnt;
    req_en = 1'b1; req_rw = 1'b1; req_byte = 1'b0; req_addr = 16'h4000; req_wdata = 16'h5566;
    @(posedge Clock); #1;
    req_en = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("abt_hi_strobe", {15'd0, mem_we0, mem_addr0}, 32'h14001);
    rst0 = 1'b1;
    @(posedge Clock); #1;
    check("abt_rdata", 32'(rsp_rdata0), 32'h0);
    check("abt_addr", 32'(mem_addr0), 32'h0);
    check("abt_ctl", {19'd0, rsp_done0, busy0, mem_we0, mem_re0, mem_wdata0}, 32'h0);
    rst0 = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    check("abt_no_done", 32'(done0_cnt - d0), 32'd0);
    check("abt_ram", {16'd0, ram[16'h4001], ram[16'h4000]}, 32'h7766);

    // Three wait states
    rst0 = 1'b1; rst3 = 1'b0;
    @(posedge Clock); #1;
    r0 = re3_cyc.size();
    run_req(1'b1, 1'b0, 1'b0, 16'h1000, 16'h0, de);
    check("ws3_wrd_done_edge", 32'(de), 32'd11);
    check("ws3_wrd_rdata", 32'(rsp_rdata3), 32'h1234);
    check("ws3_re_count", 32'(re3_cyc.size() - r0), 32'd2);
    check("ws3_re_spacing", 32'(re3_cyc[r0 + 1] - re3_cyc[r0]), 32'd5);
    run_req(1'b1, 1'b0, 1'b1, 16'h2001, 16'h0, de);
    check("ws3_byt_done_edge", 32'(de), 32'd6);
    check("ws3_byt_rdata", 32'(rsp_rdata3), 32'h00AB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
